// File: rtl/nlm_line_sequencer_if.sv
// nlm_line_sequencer_if: upstream pixel stream with valid/ready handshake.
// master drives the pixel; slave (the sequencer) returns ready.
interface nlm_line_sequencer_if #(
  parameter int DATA_WIDTH = 12
) ();
  logic                  pix_valid_i;
  logic                  pix_sof_i;
  logic [DATA_WIDTH-1:0] pix_data_i;
  logic                  pix_ready_o;

  modport master (
    output pix_valid_i,
    output pix_sof_i,
    output pix_data_i,
    input  pix_ready_o
  );

  modport slave (
    input  pix_valid_i,
    input  pix_sof_i,
    input  pix_data_i,
    output pix_ready_o
  );
endinterface

// File: rtl/nlm_line_sequencer.sv
// nlm_line_sequencer: regenerates clean frame/line timing for the NLM line buffer.
// Define NLM_SEQ_STALL_CHECK_EN to abort a frame on any mid-line valid gap.
module nlm_line_sequencer #(
  parameter int IMAGE_WIDTH  = 4032,
  parameter int IMAGE_HEIGHT = 3024,
  parameter int HBLANK       = 16,
  parameter int DATA_WIDTH   = 12,
  localparam int COL_W = $clog2(IMAGE_WIDTH),
  localparam int ROW_W = $clog2(IMAGE_HEIGHT)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en_i,
  nlm_line_sequencer_if.slave   pix,
  output logic                  valid_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  frame_sync_o,
  output logic                  line_sync_o,
  output logic [COL_W-1:0]      col_o,
  output logic [ROW_W-1:0]      row_o,
  output logic                  frame_done_o,
  output logic [1:0]            err_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LINE   = 3'd1;
  localparam logic [2:0] S_ACTIVE = 3'd2;
  localparam logic [2:0] S_BLANK  = 3'd3;
  localparam logic [2:0] S_DONE   = 3'd4;

  localparam int BLK_W = $clog2(HBLANK + 1);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMAGE_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMAGE_HEIGHT - 1);
  localparam logic [BLK_W-1:0] BLK_LOAD = BLK_W'(HBLANK - 1);

  logic [2:0]       state, state_n;
  logic [COL_W-1:0] col_q, col_n, ocol;
  logic [ROW_W-1:0] row_q, row_n, orow;
  logic [BLK_W-1:0] cnt_q, cnt_n;
  logic [1:0]       err_q, err_set;
  logic             ready, xfer;
  logic             emit, fsync, lsync;

  always_comb begin
    ready = 1'b0;
    unique case (1'b1)
      state == S_IDLE:   ready = en_i;
      state == S_LINE,
      state == S_ACTIVE: ready = 1'b1;
      default:           ready = 1'b0;
    endcase
  end

  // Gate with reset so ready is low while reset is held.
  assign pix.pix_ready_o = ready & rst_n;
  assign xfer = pix.pix_valid_i & ready;

  always_comb begin
    state_n = state;
    col_n   = col_q;
    row_n   = row_q;
    cnt_n   = cnt_q;
    ocol    = col_q;
    orow    = row_q;
    emit    = 1'b0;
    fsync   = 1'b0;
    lsync   = 1'b0;
    err_set = 2'b00;
    unique case (1'b1)
      state == S_IDLE: begin
        if (xfer && pix.pix_sof_i) begin
          emit    = 1'b1;
          fsync   = 1'b1;
          lsync   = 1'b1;
          ocol    = '0;
          orow    = '0;
          col_n   = COL_W'(1);
          row_n   = '0;
          state_n = S_ACTIVE;
        end
      end
      state == S_LINE: begin
        if (xfer && pix.pix_sof_i) begin
          err_set[0] = 1'b1;
          state_n    = S_IDLE;
        end else if (xfer) begin
          emit    = 1'b1;
          lsync   = 1'b1;
          ocol    = '0;
          col_n   = COL_W'(1);
          state_n = S_ACTIVE;
        end
      end
      state == S_ACTIVE: begin
        if (xfer && pix.pix_sof_i) begin
          err_set[0] = 1'b1;
          state_n    = S_IDLE;
        end else if (xfer) begin
          emit = 1'b1;
          if (col_q == COL_LAST) begin
            col_n = '0;
            if (row_q == ROW_LAST) begin
              state_n = S_DONE;
            end else begin
              row_n   = row_q + ROW_W'(1);
              cnt_n   = BLK_LOAD;
              state_n = S_BLANK;
            end
          end else begin
            col_n = col_q + COL_W'(1);
          end
        end
`ifdef NLM_SEQ_STALL_CHECK_EN
        else begin
          err_set[1] = 1'b1;
          state_n    = S_IDLE;
        end
`endif
      end
      state == S_BLANK: begin
        if (cnt_q == '0) state_n = S_LINE;
        else cnt_n = cnt_q - BLK_W'(1);
      end
      state == S_DONE: state_n = S_IDLE;
      default:         state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      cnt_q        <= '0;
      err_q        <= 2'b00;
      valid_o      <= 1'b0;
      data_o       <= '0;
      frame_sync_o <= 1'b0;
      line_sync_o  <= 1'b0;
      col_o        <= '0;
      row_o        <= '0;
    end else begin
      state        <= state_n;
      col_q        <= col_n;
      row_q        <= row_n;
      cnt_q        <= cnt_n;
      err_q        <= en_i ? (err_q | err_set) : 2'b00;
      valid_o      <= emit;
      frame_sync_o <= fsync;
      line_sync_o  <= lsync;
      if (emit) begin
        data_o <= pix.pix_data_i;
        col_o  <= ocol;
        row_o  <= orow;
      end
    end
  end

  assign frame_done_o = (state == S_DONE);
  assign err_o        = err_q;

endmodule

// File: tb/tb_nlm_line_sequencer.sv
// tb_nlm_line_sequencer: directed vector table plus frame-level sequences.
// W=8, H=4, HBLANK=3; works with or without NLM_SEQ_STALL_CHECK_EN.
module tb_nlm_line_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en_i;
  logic        valid_o;
  logic [11:0] data_o;
  logic        frame_sync_o;
  logic        line_sync_o;
  logic [2:0]  col_o;
  logic [1:0]  row_o;
  logic        frame_done_o;
  logic [1:0]  err_o;

  int checks = 0;
  int errors = 0;
  logic rdy_seen;
  int eerr;

  nlm_line_sequencer_if #(.DATA_WIDTH(12)) pix ();

  nlm_line_sequencer #(
    .IMAGE_WIDTH (8),
    .IMAGE_HEIGHT(4),
    .HBLANK      (3),
    .DATA_WIDTH  (12)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en_i        (en_i),
    .pix         (pix),
    .valid_o     (valid_o),
    .data_o      (data_o),
    .frame_sync_o(frame_sync_o),
    .line_sync_o (line_sync_o),
    .col_o       (col_o),
    .row_o       (row_o),
    .frame_done_o(frame_done_o),
    .err_o       (err_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    int en, v, s, d;
    int rdy, ov, fs, ls, col, row, dn, err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input int en, v, s, d,
                     input int rdy, ov, fs, ls,
                     input int col, row, dn, err);
    vec_t t;
    t.en = en; t.v = v; t.s = s; t.d = d;
    t.rdy = rdy; t.ov = ov; t.fs = fs; t.ls = ls;
    t.col = col; t.row = row; t.dn = dn; t.err = err;
    vq.push_back(t);
  endtask

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic step(input int en, input int v, input int s, input int d);
    @(negedge clk);
    en_i            = (en != 0);
    pix.pix_valid_i = (v != 0);
    pix.pix_sof_i   = (s != 0);
    pix.pix_data_i  = 12'(d);
    #1 rdy_seen = pix.pix_ready_o;
    @(posedge clk);
    #1;
  endtask

  task automatic expect_out(input string nm, input int rdy, ov, fs, ls,
                            input int col, row, dn, err, d);
    chk({nm, " ready"}, int'(rdy_seen), rdy);
    chk({nm, " valid"}, int'(valid_o), ov);
    chk({nm, " fsync"}, int'(frame_sync_o), fs);
    chk({nm, " lsync"}, int'(line_sync_o), ls);
    chk({nm, " done"}, int'(frame_done_o), dn);
    chk({nm, " err"}, int'(err_o), err);
    if (ov != 0) begin
      chk({nm, " col"}, int'(col_o), col);
      chk({nm, " row"}, int'(row_o), row);
      chk({nm, " data"}, int'(data_o), d);
    end
  endtask

  // Drives one frame with valid held high; optional gap, en drop, early stop.
  task automatic run_frame(input string nm, input int gap_r, input int gap_c,
                           input int en_off_r, input int stop_at, input int base);
    int nv, nls, nfs, ndn, en, d;
    nv = 0; nls = 0; nfs = 0; ndn = 0; en = 1;
    for (int r = 0; r < 4; r++) begin
      en = (en_off_r >= 0 && r >= en_off_r) ? 0 : 1;
      for (int c = 0; c < 8; c++) begin
        if (r == gap_r && c == gap_c) begin
          step(en, 0, 0, 0);
          if (en == 0) eerr = 0;
`ifdef NLM_SEQ_STALL_CHECK_EN
          eerr = eerr | 2;
          expect_out({nm, " gap"}, 1, 0, 0, 0, 0, 0, 0, eerr, 0);
          step(1, 0, 0, 0);
          expect_out({nm, " post-abort"}, 1, 0, 0, 0, 0, 0, 0, eerr, 0);
          return;
`else
          expect_out({nm, " gap"}, 1, 0, 0, 0, 0, 0, 0, eerr, 0);
`endif
        end
        d = base + r * 16 + c;
        step(en, 1, (r == 0 && c == 0) ? 1 : 0, d);
        if (en == 0) eerr = 0;
        expect_out($sformatf("%s px r%0d c%0d", nm, r, c), 1, 1,
                   (r == 0 && c == 0) ? 1 : 0, (c == 0) ? 1 : 0,
                   c, r, (r == 3 && c == 7) ? 1 : 0, eerr, d);
        nv  += int'(valid_o);
        nls += int'(line_sync_o);
        nfs += int'(frame_sync_o);
        ndn += int'(frame_done_o);
        if (r * 8 + c == stop_at) return;
      end
      if (r < 3) begin
        for (int b = 0; b < 3; b++) begin
          step(en, 1, 0, 'hFFF);
          if (en == 0) eerr = 0;
          expect_out($sformatf("%s blank r%0d b%0d", nm, r, b),
                     0, 0, 0, 0, 0, 0, 0, eerr, 0);
        end
      end
    end
    step(en, 0, 0, 0);
    if (en == 0) eerr = 0;
    expect_out({nm, " done-cycle"}, 0, 0, 0, 0, 0, 0, 0, eerr, 0);
    chk({nm, " n_valid"}, nv, 32);
    chk({nm, " n_lsync"}, nls, 4);
    chk({nm, " n_fsync"}, nfs, 1);
    chk({nm, " n_done"}, ndn, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    en_i = 1'b1;
    pix.pix_valid_i = 1'b0;
    pix.pix_sof_i = 1'b0;
    pix.pix_data_i = 12'h0;
    eerr = 0;

    // Reset values, with en_i high to show ready is still held low.
    #12;
    chk("rst ready", int'(pix.pix_ready_o), 0);
    chk("rst valid", int'(valid_o), 0);
    chk("rst data", int'(data_o), 0);
    chk("rst fsync", int'(frame_sync_o), 0);
    chk("rst lsync", int'(line_sync_o), 0);
    chk("rst col", int'(col_o), 0);
    chk("rst row", int'(row_o), 0);
    chk("rst done", int'(frame_done_o), 0);
    chk("rst err", int'(err_o), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Pre-frame junk, sof, row 0, blank, then misplaced sof at row 1 col 4.
    for (int i = 0; i < 5; i++) add(1, 1, 0, 'h0A0 + i, 1, 0, 0, 0, 0, 0, 0, 0);
    add(1, 1, 1, 'h200, 1, 1, 1, 1, 0, 0, 0, 0);
    for (int c = 1; c < 8; c++) add(1, 1, 0, 'h200 + c, 1, 1, 0, 0, c, 0, 0, 0);
    for (int b = 0; b < 3; b++) add(1, 1, 0, 'h2EE, 0, 0, 0, 0, 7, 0, 0, 0);
    add(1, 1, 0, 'h210, 1, 1, 0, 1, 0, 1, 0, 0);
    for (int c = 1; c < 4; c++) add(1, 1, 0, 'h210 + c, 1, 1, 0, 0, c, 1, 0, 0);
    add(1, 1, 1, 'h2FF, 1, 0, 0, 0, 3, 1, 0, 1);
    add(1, 1, 0, 'h2AA, 1, 0, 0, 0, 3, 1, 0, 1);

    for (int i = 0; i < vq.size(); i++) begin
      vec_t t;
      t = vq[i];
      step(t.en, t.v, t.s, t.d);
      expect_out($sformatf("vec%0d", i), t.rdy, t.ov, t.fs, t.ls,
                 t.col, t.row, t.dn, t.err, t.d);
    end

    // Next frame runs normally with the sticky error still set.
    eerr = 1;
    run_frame("frame-err01", -1, -1, -1, -1, 'h300);

    // en_i low for one cycle clears err.
    step(0, 0, 0, 0);
    eerr = 0;
    expect_out("err-clear", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // One-cycle valid gap at row 2 col 5.
    run_frame("gap", 2, 5, -1, -1, 'h400);
    step(0, 0, 0, 0);
    eerr = 0;
    expect_out("gap-clear", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // en_i dropped from row 1 on: frame still completes.
    run_frame("en-drop", -1, -1, 1, -1, 'h500);
    step(0, 1, 1, 'h5FF);
    expect_out("en-drop sof-ignored", 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(0, 1, 1, 'h5FE);
    expect_out("en-drop sof-ignored2", 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset mid-frame at row 2 col 3, then restart from row 0.
    run_frame("pre-reset", -1, -1, -1, 19, 'h600);
    @(negedge clk);
    rst_n = 1'b0;
    pix.pix_valid_i = 1'b0;
    #1;
    chk("midrst ready", int'(pix.pix_ready_o), 0);
    chk("midrst valid", int'(valid_o), 0);
    chk("midrst data", int'(data_o), 0);
    chk("midrst fsync", int'(frame_sync_o), 0);
    chk("midrst lsync", int'(line_sync_o), 0);
    chk("midrst col", int'(col_o), 0);
    chk("midrst row", int'(row_o), 0);
    chk("midrst done", int'(frame_done_o), 0);
    chk("midrst err", int'(err_o), 0);
    @(negedge clk);
    rst_n = 1'b1;
    eerr = 0;
    run_frame("post-reset", -1, -1, -1, -1, 'h700);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
